// File: rtl/alu_result_collector.sv
// ---------------------------------------------------------------------------
// alu_result_collector
//
// Collects the per-cycle results of the four ALU units. When exactly one unit
// flag is high, that unit's result is tagged with its unit code (and the
// arithmetic carry, when it comes from the arithmetic unit) and queued in a
// first-word-fall-through FIFO. A consumer drains the FIFO with a valid/ready
// handshake. Sticky error bits report dropped results (OVERFLOW) and cycles
// with more than one unit flag high (CONFLICT).
//
// Parameters
//   ALU_WIDTH   result width
//   FIFO_DEPTH  queue entries (power of two, >= 2)
//
// Ports
//   CLK, RST                 clock; asynchronous active-high reset
//   Arith_OUT/Logic_OUT/
//   CMP_OUT/SHIFT_OUT        unit results
//   Carry_OUT                arithmetic carry
//   *_Flag                   per-unit result-valid flags
//   RES_READY                consumer accepts the head entry
//   CLR_ERR                  clears the sticky error bits
//   RES_VALID                FIFO non-empty
//   RES_DATA/UNIT/CARRY      head entry, zero while RES_VALID=0
//   FIFO_COUNT               occupancy, 0..FIFO_DEPTH
//   OVERFLOW, CONFLICT       sticky error bits
// ---------------------------------------------------------------------------
module alu_result_collector #(
   parameter int ALU_WIDTH  = 16,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                          CLK,
   input  logic                          RST,
   input  logic [ALU_WIDTH-1:0]          Arith_OUT,
   input  logic [ALU_WIDTH-1:0]          Logic_OUT,
   input  logic [ALU_WIDTH-1:0]          CMP_OUT,
   input  logic [ALU_WIDTH-1:0]          SHIFT_OUT,
   input  logic                          Carry_OUT,
   input  logic                          Arith_Flag,
   input  logic                          Logic_Flag,
   input  logic                          CMP_Flag,
   input  logic                          SHIFT_Flag,
   input  logic                          RES_READY,
   input  logic                          CLR_ERR,
   output logic                          RES_VALID,
   output logic [ALU_WIDTH-1:0]          RES_DATA,
   output logic [1:0]                    RES_UNIT,
   output logic                          RES_CARRY,
   output logic [$clog2(FIFO_DEPTH):0]   FIFO_COUNT,
   output logic                          OVERFLOW,
   output logic                          CONFLICT
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      UNIT_ARITH = 2'b00,
      UNIT_LOGIC = 2'b01,
      UNIT_CMP   = 2'b10,
      UNIT_SHIFT = 2'b11
   } unit_e;

   typedef struct packed {
      logic [ALU_WIDTH-1:0] data;
      unit_e                unit;
      logic                 carry;
   } entry_t;

   // State
   entry_t          mem_q [FIFO_DEPTH];
   logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]   count_q,  count_d;
   logic            overflow_q, overflow_d;
   logic            conflict_q, conflict_d;

   // Decode
   logic [3:0]      flags;
   logic            multi_flag;
   logic            push_req;
   logic            push_ok;
   logic            pop;
   logic            full;
   logic            empty;
   logic            overflow_set;
   entry_t          new_entry;
   entry_t          head;

   assign flags = {SHIFT_Flag, CMP_Flag, Logic_Flag, Arith_Flag};

   // NOTE: every signal assigned in an always_comb gets a default first, so no
   // path through the case leaves it unassigned and no latch is inferred.
   always_comb begin
      new_entry = '0;
      case (flags)
         4'b0001: begin
            new_entry.data  = Arith_OUT;
            new_entry.unit  = UNIT_ARITH;
            new_entry.carry = Carry_OUT;
         end
         4'b0010: begin
            new_entry.data = Logic_OUT;
            new_entry.unit = UNIT_LOGIC;
         end
         4'b0100: begin
            new_entry.data = CMP_OUT;
            new_entry.unit = UNIT_CMP;
         end
         4'b1000: begin
            new_entry.data = SHIFT_OUT;
            new_entry.unit = UNIT_SHIFT;
         end
         default: new_entry = '0;
      endcase
   end

   // x & (x-1) clears the lowest set bit; anything left means two or more flags.
   assign multi_flag   = (flags & (flags - 4'd1)) != 4'd0;
   assign push_req     = (flags != 4'd0) && !multi_flag;

   assign empty        = (count_q == '0);
   assign full         = (count_q == FULL_CNT);
   assign pop          = !empty && RES_READY;
   // A pop in the same cycle frees the slot, so a full FIFO still accepts.
   assign push_ok      = push_req && (!full || pop);
   assign overflow_set = push_req && full && !pop;

   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)     rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push_ok, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
      // Set has priority over clear so a coincident event is never lost.
      overflow_d = overflow_set ? 1'b1 : (CLR_ERR ? 1'b0 : overflow_q);
      conflict_d = multi_flag   ? 1'b1 : (CLR_ERR ? 1'b0 : conflict_q);
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
         conflict_q <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
         conflict_q <= conflict_d;
      end
   end

   // NOTE: the storage array has no reset; its contents are never observed
   // while empty because the outputs are masked by RES_VALID.
   always_ff @(posedge CLK) begin
      if (push_ok) mem_q[wr_ptr_q] <= new_entry;
   end

   assign head       = mem_q[rd_ptr_q];
   assign RES_VALID  = !empty;
   assign RES_DATA   = RES_VALID ? head.data  : '0;
   assign RES_UNIT   = RES_VALID ? head.unit  : 2'b00;
   assign RES_CARRY  = RES_VALID ? head.carry : 1'b0;
   assign FIFO_COUNT = count_q;
   assign OVERFLOW   = overflow_q;
   assign CONFLICT   = conflict_q;

endmodule

// File: tb/tb_alu_result_collector.sv
// ---------------------------------------------------------------------------
// tb_alu_result_collector
//
// Directed bench for alu_result_collector. A table of {inputs, expected
// outputs} records is applied one clock per record; reset and back-to-back
// wrap-around are hand-written sequences.
// ---------------------------------------------------------------------------
module tb_alu_result_collector;

   logic        CLK = 1'b0;
   logic        RST;
   logic [15:0] Arith_OUT, Logic_OUT, CMP_OUT, SHIFT_OUT;
   logic        Carry_OUT;
   logic        Arith_Flag, Logic_Flag, CMP_Flag, SHIFT_Flag;
   logic        RES_READY, CLR_ERR;
   logic        RES_VALID;
   logic [15:0] RES_DATA;
   logic [1:0]  RES_UNIT;
   logic        RES_CARRY;
   logic [2:0]  FIFO_COUNT;
   logic        OVERFLOW, CONFLICT;

   int n_checks = 0;
   int n_fail   = 0;

   alu_result_collector #(.ALU_WIDTH(16), .FIFO_DEPTH(4)) dut (
      .CLK        (CLK),
      .RST        (RST),
      .Arith_OUT  (Arith_OUT),
      .Logic_OUT  (Logic_OUT),
      .CMP_OUT    (CMP_OUT),
      .SHIFT_OUT  (SHIFT_OUT),
      .Carry_OUT  (Carry_OUT),
      .Arith_Flag (Arith_Flag),
      .Logic_Flag (Logic_Flag),
      .CMP_Flag   (CMP_Flag),
      .SHIFT_Flag (SHIFT_Flag),
      .RES_READY  (RES_READY),
      .CLR_ERR    (CLR_ERR),
      .RES_VALID  (RES_VALID),
      .RES_DATA   (RES_DATA),
      .RES_UNIT   (RES_UNIT),
      .RES_CARRY  (RES_CARRY),
      .FIFO_COUNT (FIFO_COUNT),
      .OVERFLOW   (OVERFLOW),
      .CONFLICT   (CONFLICT)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic [3:0]  flg;   // {shift, cmp, logic, arith}
      logic [15:0] a, l, c, s;
      logic        cy, rdy, clr;
      logic        ev;
      logic [15:0] ed;
      logic [1:0]  eu;
      logic        ec;
      logic [2:0]  ecnt;
      logic        eov, ecf;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(logic [3:0] flg, logic [15:0] a, logic [15:0] l,
                               logic [15:0] c, logic [15:0] s, logic cy,
                               logic rdy, logic clr, logic ev, logic [15:0] ed,
                               logic [1:0] eu, logic ec, logic [2:0] ecnt,
                               logic eov, logic ecf);
      vec_t v;
      v.flg = flg; v.a = a; v.l = l; v.c = c; v.s = s;
      v.cy = cy; v.rdy = rdy; v.clr = clr;
      v.ev = ev; v.ed = ed; v.eu = eu; v.ec = ec;
      v.ecnt = ecnt; v.eov = eov; v.ecf = ecf;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic [3:0] flg, input logic [15:0] a, input logic [15:0] l,
                        input logic [15:0] c, input logic [15:0] s, input logic cy,
                        input logic rdy, input logic clr);
      Arith_Flag = flg[0]; Logic_Flag = flg[1]; CMP_Flag = flg[2]; SHIFT_Flag = flg[3];
      Arith_OUT = a; Logic_OUT = l; CMP_OUT = c; SHIFT_OUT = s;
      Carry_OUT = cy; RES_READY = rdy; CLR_ERR = clr;
   endtask

   task automatic check_all(input string tag, input logic ev, input logic [15:0] ed,
                            input logic [1:0] eu, input logic ec, input logic [2:0] ecnt,
                            input logic eov, input logic ecf);
      check({tag, " valid"}, 32'(RES_VALID),  32'(ev));
      check({tag, " data"},  32'(RES_DATA),   32'(ed));
      check({tag, " unit"},  32'(RES_UNIT),   32'(eu));
      check({tag, " carry"}, 32'(RES_CARRY),  32'(ec));
      check({tag, " count"}, 32'(FIFO_COUNT), 32'(ecnt));
      check({tag, " ovf"},   32'(OVERFLOW),   32'(eov));
      check({tag, " cnf"},   32'(CONFLICT),   32'(ecf));
   endtask

   initial begin
      // Expected values are the post-edge outputs after applying each record.
      //                flg    arith    logic    cmp      shift   cy rdy clr  v  data     u   c cnt ov cf
      // Tagging and order
      vecs.push_back(mk(4'b0001, 16'hFFFF, 16'h0, 16'h0, 16'h0, 1, 0, 0, 1, 16'hFFFF, 2'd0, 1, 3'd1, 0, 0));
      vecs.push_back(mk(4'b0100, 16'h0, 16'h0, 16'h0001, 16'h0, 1, 0, 0, 1, 16'hFFFF, 2'd0, 1, 3'd2, 0, 0));
      vecs.push_back(mk(4'b1000, 16'h0, 16'h0, 16'h0, 16'h8000, 0, 0, 0, 1, 16'hFFFF, 2'd0, 1, 3'd3, 0, 0));
      vecs.push_back(mk(4'b0000, 16'h0, 16'h0, 16'h0, 16'h0, 0, 1, 0, 1, 16'h0001, 2'd2, 0, 3'd2, 0, 0));
      vecs.push_back(mk(4'b0000, 16'h0, 16'h0, 16'h0, 16'h0, 0, 1, 0, 1, 16'h8000, 2'd3, 0, 3'd1, 0, 0));
      vecs.push_back(mk(4'b0000, 16'h0, 16'h0, 16'h0, 16'h0, 0, 1, 0, 0, 16'h0000, 2'd0, 0, 3'd0, 0, 0));
      // Ready while empty is ignored
      vecs.push_back(mk(4'b0000, 16'h0, 16'h0, 16'h0, 16'h0, 0, 1, 0, 0, 16'h0000, 2'd0, 0, 3'd0, 0, 0));
      // Overflow: five logic pushes into a depth-4 FIFO
      vecs.push_back(mk(4'b0010, 16'h0, 16'h0001, 16'h0, 16'h0, 1, 0, 0, 1, 16'h0001, 2'd1, 0, 3'd1, 0, 0));
      vecs.push_back(mk(4'b0010, 16'h0, 16'h0002, 16'h0, 16'h0, 0, 0, 0, 1, 16'h0001, 2'd1, 0, 3'd2, 0, 0));
      vecs.push_back(mk(4'b0010, 16'h0, 16'h0003, 16'h0, 16'h0, 0, 0, 0, 1, 16'h0001, 2'd1, 0, 3'd3, 0, 0));
      vecs.push_back(mk(4'b0010, 16'h0, 16'h0004, 16'h0, 16'h0, 0, 0, 0, 1, 16'h0001, 2'd1, 0, 3'd4, 0, 0));
      vecs.push_back(mk(4'b0010, 16'h0, 16'h0005, 16'h0, 16'h0, 0, 0, 0, 1, 16'h0001, 2'd1, 0, 3'd4, 1, 0));
      vecs.push_back(mk(4'b0000, 16'h0, 16'h0, 16'h0, 16'h0, 0, 1, 0, 1, 16'h0002, 2'd1, 0, 3'd3, 1, 0));
      vecs.push_back(mk(4'b0000, 16'h0, 16'h0, 16'h0, 16'h0, 0, 1, 0, 1, 16'h0003, 2'd1, 0, 3'd2, 1, 0));
      vecs.push_back(mk(4'b0000, 16'h0, 16'h0, 16'h0, 16'h0, 0, 1, 0, 1, 16'h0004, 2'd1, 0, 3'd1, 1, 0));
      vecs.push_back(mk(4'b0000, 16'h0, 16'h0, 16'h0, 16'h0, 0, 1, 0, 0, 16'h0000, 2'd0, 0, 3'd0, 1, 0));
      vecs.push_back(mk(4'b0000, 16'h0, 16'h0, 16'h0, 16'h0, 0, 0, 1, 0, 16'h0000, 2'd0, 0, 3'd0, 0, 0));
      // Full with simultaneous push and pop
      vecs.push_back(mk(4'b0010, 16'h0, 16'h0011, 16'h0, 16'h0, 0, 0, 0, 1, 16'h0011, 2'd1, 0, 3'd1, 0, 0));
      vecs.push_back(mk(4'b0010, 16'h0, 16'h0012, 16'h0, 16'h0, 0, 0, 0, 1, 16'h0011, 2'd1, 0, 3'd2, 0, 0));
      vecs.push_back(mk(4'b0010, 16'h0, 16'h0013, 16'h0, 16'h0, 0, 0, 0, 1, 16'h0011, 2'd1, 0, 3'd3, 0, 0));
      vecs.push_back(mk(4'b0010, 16'h0, 16'h0014, 16'h0, 16'h0, 0, 0, 0, 1, 16'h0011, 2'd1, 0, 3'd4, 0, 0));
      vecs.push_back(mk(4'b0010, 16'h0, 16'h00AA, 16'h0, 16'h0, 0, 1, 0, 1, 16'h0012, 2'd1, 0, 3'd4, 0, 0));
      vecs.push_back(mk(4'b0000, 16'h0, 16'h0, 16'h0, 16'h0, 0, 1, 0, 1, 16'h0013, 2'd1, 0, 3'd3, 0, 0));
      vecs.push_back(mk(4'b0000, 16'h0, 16'h0, 16'h0, 16'h0, 0, 1, 0, 1, 16'h0014, 2'd1, 0, 3'd2, 0, 0));
      vecs.push_back(mk(4'b0000, 16'h0, 16'h0, 16'h0, 16'h0, 0, 1, 0, 1, 16'h00AA, 2'd1, 0, 3'd1, 0, 0));
      vecs.push_back(mk(4'b0000, 16'h0, 16'h0, 16'h0, 16'h0, 0, 1, 0, 0, 16'h0000, 2'd0, 0, 3'd0, 0, 0));
      // Conflict, clear coinciding with a new conflict, then clear alone
      vecs.push_back(mk(4'b0011, 16'h5555, 16'h6666, 16'h0, 16'h0, 1, 0, 0, 0, 16'h0000, 2'd0, 0, 3'd0, 0, 1));
      vecs.push_back(mk(4'b1100, 16'h0, 16'h0, 16'h7777, 16'h8888, 0, 0, 1, 0, 16'h0000, 2'd0, 0, 3'd0, 0, 1));
      vecs.push_back(mk(4'b0000, 16'h0, 16'h0, 16'h0, 16'h0, 0, 0, 1, 0, 16'h0000, 2'd0, 0, 3'd0, 0, 0));
      // Arith entry with carry 0
      vecs.push_back(mk(4'b0001, 16'h1234, 16'h0, 16'h0, 16'h0, 0, 0, 0, 1, 16'h1234, 2'd0, 0, 3'd1, 0, 0));
      vecs.push_back(mk(4'b0000, 16'h0, 16'h0, 16'h0, 16'h0, 0, 1, 0, 0, 16'h0000, 2'd0, 0, 3'd0, 0, 0));

      // Initial reset
      RST = 1'b1;
      drive(4'b0000, 16'h0, 16'h0, 16'h0, 16'h0, 0, 0, 0);
      #1;
      check_all("reset", 0, 16'h0, 2'd0, 0, 3'd0, 0, 0);
      @(negedge CLK);
      @(negedge CLK);
      RST = 1'b0;

      // Table-driven vectors: drive on negedge, check 1 time unit after posedge
      for (int i = 0; i < vecs.size(); i++) begin
         @(negedge CLK);
         drive(vecs[i].flg, vecs[i].a, vecs[i].l, vecs[i].c, vecs[i].s,
               vecs[i].cy, vecs[i].rdy, vecs[i].clr);
         @(posedge CLK);
         #1;
         check_all($sformatf("vec%0d", i), vecs[i].ev, vecs[i].ed, vecs[i].eu,
                   vecs[i].ec, vecs[i].ecnt, vecs[i].eov, vecs[i].ecf);
      end

      // Reset mid-stream with three entries queued
      for (int i = 0; i < 3; i++) begin
         @(negedge CLK);
         drive(4'b1000, 16'h0, 16'h0, 16'h0, 16'h0F00 + 16'(i), 0, 0, 0);
         @(posedge CLK);
      end
      #1;
      check_all("prefill", 1, 16'h0F00, 2'd3, 0, 3'd3, 0, 0);
      // Keep an arith flag high through reset; it must be ignored
      drive(4'b0001, 16'hBEEF, 16'h0, 16'h0, 16'h0, 1, 0, 0);
      #1;
      RST = 1'b1;
      #1;
      check_all("async rst", 0, 16'h0, 2'd0, 0, 3'd0, 0, 0);
      @(posedge CLK);
      #1;
      check_all("rst hold", 0, 16'h0, 2'd0, 0, 3'd0, 0, 0);
      @(negedge CLK);
      drive(4'b0000, 16'h0, 16'h0, 16'h0, 16'h0, 0, 0, 0);
      RST = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(posedge CLK);
         #1;
         check_all($sformatf("idle%0d", i), 0, 16'h0, 2'd0, 0, 3'd0, 0, 0);
      end

      // Wrap-around: back-to-back push and pop
      for (int i = 0; i < 10; i++) begin
         @(negedge CLK);
         drive(4'b0010, 16'h0, 16'h0100 + 16'(i), 16'h0, 16'h0, 1, 1, 0);
         @(posedge CLK);
         #1;
         check_all($sformatf("wrap%0d", i), 1, 16'h0100 + 16'(i), 2'd1, 0, 3'd1, 0, 0);
      end
      @(negedge CLK);
      drive(4'b0000, 16'h0, 16'h0, 16'h0, 16'h0, 0, 1, 0);
      @(posedge CLK);
      #1;
      check_all("wrap end", 0, 16'h0, 2'd0, 0, 3'd0, 0, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
